// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two prioritised
// write ports with optional same-cycle bypass, hardwired-zero entry 0, sequential clear engine.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic                wr_conflict
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   cidx, cidx_next;
    logic            ready_next;
    logic            conflict_next;
    logic [XLEN-1:0] mem [NREGS];

    logic wr_en;
    logic same_addr;
    logic wr0;
    logic wr1;

    // A write only lands in RUN without a clear request; port 1 wins a collision.
    assign wr_en     = (state == RUN) && !clear_req && !reset;
    assign same_addr = we0 && we1 && (wa0 == wa1);
    assign wr1       = wr_en && we1 && (wa1 != '0);
    assign wr0       = wr_en && we0 && (wa0 != '0) && !same_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            cidx        <= AW'(1);
            ready       <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_next;
            cidx        <= cidx_next;
            ready       <= ready_next;
            wr_conflict <= conflict_next;
        end
    end

    always_comb begin
        state_next    = state;
        cidx_next     = cidx;
        ready_next    = ready;
        conflict_next = 1'b0;
        case (state)
            RUN: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cidx_next  = AW'(1);
                    ready_next = 1'b0;
                end else begin
                    conflict_next = same_addr && (wa0 != '0);
                end
            end
            CLEAR: begin
                if (cidx == AW'(NREGS - 1)) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end else begin
                    cidx_next = cidx + AW'(1);
                end
            end
            default: begin
                state_next = CLEAR;
                cidx_next  = AW'(1);
                ready_next = 1'b0;
            end
        endcase
    end

    // Array storage carries no reset; the clear engine establishes known contents.
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[cidx] <= '0;
        end else begin
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = ra[k*AW +: AW];

        always_comb begin
            val = mem[addr];
            if (addr == '0 || state == CLEAR) begin
                val = '0;
            end else if (BYPASS != 0 && wr1 && wa1 == addr) begin
                val = wd1;
            end else if (BYPASS != 0 && wr0 && wa0 == addr) begin
                val = wd0;
            end
        end

        assign rd[k*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing 4-read-port
// instance share all stimulus and are checked against hand-derived expectations.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear_req;
    logic         we0, we1;
    logic [4:0]   wa0, wa1;
    logic [31:0]  wd0, wd1;
    logic [19:0]  ra;
    logic [127:0] rd_byp, rd_nb;
    logic         ready_byp, ready_nb;
    logic         conf_byp, conf_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .AW(5), .NRD(4), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_byp),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_byp), .wr_conflict(conf_byp)
    );

    regfile_mp #(.XLEN(32), .AW(5), .NRD(4), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_nb),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_nb), .wr_conflict(conf_nb)
    );

    typedef struct packed {
        logic         we0;
        logic [4:0]   wa0;
        logic [31:0]  wd0;
        logic         we1;
        logic [4:0]   wa1;
        logic [31:0]  wd1;
        logic [19:0]  ra;
        logic [127:0] rd_byp;
        logic [127:0] rd_nb;
        logic         conflict;
    } vec_t;

    typedef struct packed {
        logic [127:0] byp;
        logic [127:0] nb;
        logic         conflict;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [19:0] r, input logic [127:0] eb,
                                 input logic [127:0] en, input logic c);
        vec_t v;
        v = '{w0, a0, d0, w1, a1, d1, r, eb, en, c};
        return v;
    endfunction

    task automatic idle_inputs();
        clear_req = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that started a clear; counts cycles with ready low.
    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!ready_byp && n < 100) begin
            check({name, " rd_byp mid-clear"}, rd_byp, '0);
            check({name, " rd_nb mid-clear"}, rd_nb, '0);
            check({name, " conflict mid-clear"}, {126'd0, conf_byp, conf_nb}, '0);
            n++;
            next_cycle();
            ra = 20'($urandom);
            @(negedge clk);
        end
        check({name, " ready-low cycles"}, 128'(n), 128'd31);
        check({name, " ready_nb"}, 128'(ready_nb), 128'd1);
        next_cycle();
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 1; i < 32; i++) begin
            ra = {4{5'(i)}};
            @(negedge clk);
            check({name, " rd_byp"}, rd_byp, '0);
            check({name, " rd_nb"}, rd_nb, '0);
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        ra    = '0;
        idle_inputs();

        tbl[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd5},
                      {96'd0, 32'hDEADBEEF}, 128'd0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd5},
                      {96'd0, 32'hDEADBEEF}, {96'd0, 32'hDEADBEEF}, 0);
        tbl[2]  = mkv(1, 7, 32'h11, 1, 7, 32'h22, {5'd0, 5'd0, 5'd0, 5'd7},
                      {96'd0, 32'h22}, 128'd0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd7},
                      {96'd0, 32'h22}, {96'd0, 32'h22}, 1);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0, 5'd7},
                      {96'd0, 32'h22}, {96'd0, 32'h22}, 0);
        tbl[5]  = mkv(1, 0, 32'h11, 1, 0, 32'h22, {5'd0, 5'd0, 5'd7, 5'd0},
                      {64'd0, 32'h22, 32'd0}, {64'd0, 32'h22, 32'd0}, 0);
        tbl[6]  = mkv(0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd7, 5'd0},
                      {64'd0, 32'h22, 32'd0}, {64'd0, 32'h22, 32'd0}, 0);
        tbl[7]  = mkv(1, 3, 32'hA3, 1, 9, 32'hB9, {5'd31, 5'd0, 5'd9, 5'd3},
                      {32'd0, 32'd0, 32'hB9, 32'hA3}, 128'd0, 0);
        tbl[8]  = mkv(1, 31, 32'hC31, 0, 0, 0, {5'd31, 5'd0, 5'd9, 5'd3},
                      {32'hC31, 32'd0, 32'hB9, 32'hA3}, {32'd0, 32'd0, 32'hB9, 32'hA3}, 0);
        tbl[9]  = mkv(0, 0, 0, 0, 0, 0, {5'd31, 5'd0, 5'd9, 5'd3},
                      {32'hC31, 32'd0, 32'hB9, 32'hA3}, {32'hC31, 32'd0, 32'hB9, 32'hA3}, 0);
        tbl[10] = mkv(1, 9, 32'h5678, 1, 3, 32'h1234, {5'd0, 5'd5, 5'd3, 5'd9},
                      {32'd0, 32'hDEADBEEF, 32'h1234, 32'h5678},
                      {32'd0, 32'hDEADBEEF, 32'hA3, 32'hB9}, 0);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, {5'd0, 5'd5, 5'd3, 5'd9},
                      {32'd0, 32'hDEADBEEF, 32'h1234, 32'h5678},
                      {32'd0, 32'hDEADBEEF, 32'h1234, 32'h5678}, 0);

        // Power-up reset held three cycles.
        next_cycle();
        check("reset ready", {126'd0, ready_byp, ready_nb}, '0);
        check("reset wr_conflict", {126'd0, conf_byp, conf_nb}, '0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        wait_ready("initial clear");
        check_all_zero("after initial clear");

        // Table-driven RUN traffic through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            ra  = tbl[i].ra;
            sb.push_back('{tbl[i].rd_byp, tbl[i].rd_nb, tbl[i].conflict});
            @(negedge clk);
            begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("vec%0d rd_byp", i), rd_byp, e.byp);
                check($sformatf("vec%0d rd_nb", i), rd_nb, e.nb);
                check($sformatf("vec%0d wr_conflict", i), {126'd0, conf_byp, conf_nb},
                      {126'd0, e.conflict, e.conflict});
                check($sformatf("vec%0d ready", i), {126'd0, ready_byp, ready_nb}, 128'd3);
            end
            next_cycle();
        end
        idle_inputs();

        // Fill every entry, then request a clear with writes that must be dropped.
        for (int i = 1; i < 32; i++) begin
            we0 = 1'b1; wa0 = 5'(i); wd0 = 32'hFFFFFFFF;
            next_cycle();
        end
        idle_inputs();
        clear_req = 1'b1;
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h77;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h66;
        ra  = {5'd31, 5'd1, 5'd6, 5'd4};
        @(negedge clk);
        check("clear_req cycle rd_byp", rd_byp, {4{32'hFFFFFFFF}});
        check("clear_req cycle rd_nb", rd_nb, {4{32'hFFFFFFFF}});
        next_cycle();
        idle_inputs();
        wait_ready("clear_req");
        check_all_zero("after clear_req");

        // Reset lands mid-clear when the index reaches 12.
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h55;
        next_cycle();
        idle_inputs();
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        repeat (11) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("mid-clear reset ready", {126'd0, ready_byp, ready_nb}, '0);
        wait_ready("mid-clear reset");
        ra = {5'd20, 5'd20, 5'd20, 5'd20};
        @(negedge clk);
        check("entry 20 after restart", rd_byp, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined core, successor to the single-write, dual-read file. Provides NRD combinational read ports, two prioritised write ports with optional write-to-read bypass, a hardwired-zero entry 0, and a sequential clear engine. The engine zeroes the array one entry per cycle after reset or on request, with a `ready` handshake. Sits between decode (read addresses) and writeback (two retiring results per cycle).

## Interface
- `XLEN`, 32: data width in bits.
- `AW`, 5: address width; `NREGS` = 2**AW entries.
- `NRD`, 2: number of read ports (1..4).
- `BYPASS`, 1: 1 = reads return same-cycle write data; 0 = reads return array contents only.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high; starts a clear sequence.
- `clear_req` in 1: single-cycle request to zero the whole file; honoured only while `ready`=1.
- `ready` out 1: registered; 1 = file usable, 0 = clear in progress.
- `we0` in 1: write enable, port 0.
- `wa0` in AW: write address, port 0.
- `wd0` in XLEN: write data, port 0.
- `we1` in 1: write enable, port 1; has priority over port 0.
- `wa1` in AW: write address, port 1.
- `wd1` in XLEN: write data, port 1.
- `ra` in NRD*AW: packed read addresses; port k at bits [k*AW +: AW].
- `rd` out NRD*XLEN: packed read data; port k at bits [k*XLEN +: XLEN]; combinational.
- `wr_conflict` out 1: registered one-cycle pulse; both ports wrote the same nonzero address in the previous cycle.

## Operation
- States: RUN, CLEAR. Clear index `cidx` is AW bits wide.
- Reset, at any state or index: state <= CLEAR, `cidx` <= 1, `ready` <= 0, `wr_conflict` <= 0. A clear in progress restarts from 1.
- CLEAR, each edge: entry[`cidx`] <= 0, `cidx` <= `cidx`+1.
  - At `cidx` = NREGS-1: write that entry, then state <= RUN, `ready` <= 1.
  - No wrap past NREGS-1.
- RUN with `clear_req`=1: same transition as reset, except the array is not touched that edge. Writes on that edge are dropped.
- Writes are performed only in RUN with `clear_req`=0.
  - Address 0 is never written; entry 0 always reads 0.
  - `we1` and `we0` to the same address: port 1 data stored, port 0 discarded. `wr_conflict` <= 1 on the next edge if that address is nonzero.
  - Different addresses: both are stored on the same edge.
- Reads, port k:
  - `ra`=0 returns 0.
  - Else in CLEAR, returns 0 (array not trusted mid-clear).
  - Else with BYPASS=1 and `we1` matching, returns `wd1`.
  - Else with BYPASS=1 and `we0` matching, returns `wd0`.
  - Else returns array contents.
- Bypass applies only when the write would actually be performed (RUN, `clear_req`=0).
- Array power-on contents are don't-care; correctness relies on the reset clear.

## Timing
- Reset values: `ready`=0, `wr_conflict`=0, state CLEAR, `cidx`=1.
- Clear latency: NREGS-1 edges after the last edge with `reset`=1 (31 for AW=5). `ready` rises on the edge that clears entry NREGS-1.
- Write latency: data visible in the array the cycle after the edge. Visible to reads in the same cycle only when BYPASS=1.
- Read latency: zero, combinational from `ra`, write ports, and state.
- `wr_conflict`: high exactly one cycle, starting the cycle after the colliding edge.

## Test plan
- Reset held 3 cycles, then released: `ready`=0 for exactly 31 cycles, then 1. All `ra`=1..31 read 0.
- RUN, `we0`=1, `wa0`=5, `wd0`=0xDEADBEEF, `ra`[0]=5:
  - BYPASS=1: `rd`[0]=0xDEADBEEF in the same cycle.
  - BYPASS=0: 0 in the same cycle, then 0xDEADBEEF in the next cycle.
- Both ports write address 7 (`wd0`=0x11, `wd1`=0x22): entry 7 reads 0x22 and `wr_conflict`=1 for one cycle. Repeat at address 0: entry 0 reads 0 and `wr_conflict` stays 0.
- Write 0xFFFFFFFF to entries 1..31, then pulse `clear_req`:
  - Writes in the request cycle are dropped.
  - `ready` is low 31 cycles; all reads return 0 during and after the clear.
- Assert `reset` mid-clear at `cidx`=12: `cidx` restarts at 1, and `ready` returns 31 cycles after `reset` deasserts.
- NRD=4, all ports read distinct addresses 3, 9, 0, 31 holding known values: each port returns its own entry, and port 2 returns 0.
